// File: rtl/fifo_param_if.sv
// Producer/consumer bundle for the parametrised FIFO.
// The slave modport faces the FIFO, the master faces its user.
interface fifo_param_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3
);
  logic                  wr_en;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] din;
  logic [DATA_WIDTH-1:0] dout;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic                  wr_ack;
  logic                  wr_err;
  logic                  rd_ack;
  logic                  rd_err;
  logic [ADDR_WIDTH:0]   data_count;

  modport master (
    output wr_en, rd_en, din,
    input  dout, full, empty,
    input  almost_full, almost_empty,
    input  wr_ack, wr_err, rd_ack, rd_err,
    input  data_count
  );

  modport slave (
    input  wr_en, rd_en, din,
    output dout, full, empty,
    output almost_full, almost_empty,
    output wr_ack, wr_err, rd_ack, rd_err,
    output data_count
  );
endinterface

// File: rtl/fifo_param.sv
// Single-clock parametrised FIFO: controller FSM plus storage.
// Registered dout, ack/err strobes and threshold flags.
module fifo_param #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3,
  parameter int AF_THRESH  = 7,
  parameter int AE_THRESH  = 1
) (
  input logic         clk,
  input logic         reset_n,
  fifo_param_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;

  typedef enum logic [2:0] {
    INIT     = 3'b000,
    WRITE    = 3'b001,
    READ     = 3'b010,
    WR_ERROR = 3'b011,
    RD_ERROR = 3'b100,
    NO_OP    = 3'b101,
    WR_RD    = 3'b110
  } state_t;

  state_t                state;
  state_t                nxt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] head;
  logic [ADDR_WIDTH-1:0] tail;
  logic [CW-1:0]         count;
  logic [CW-1:0]         cnt_nxt;
  logic [DATA_WIDTH-1:0] dout;
  logic                  rd_miss;
  logic                  miss;
  logic                  wr_ok;
  logic                  rd_ok;
  logic                  is_full;
  logic                  is_empty;
  logic                  full;
  logic                  empty;
  logic                  afull;
  logic                  aempty;

  assign is_full  = count == CW'(DEPTH);
  assign is_empty = count == '0;

  // Next state depends only on the request and occupancy,
  // so an illegal encoding never persists past one edge.
  always_comb begin
    nxt  = NO_OP;
    miss = 1'b0;
    unique case (1'b1)
      bus.wr_en && bus.rd_en: begin
        if (is_empty) begin
          nxt  = WRITE;
          miss = 1'b1;
        end else begin
          nxt = WR_RD;
        end
      end
      bus.wr_en && !bus.rd_en:
        nxt = is_full ? WR_ERROR : WRITE;
      !bus.wr_en && bus.rd_en:
        nxt = is_empty ? RD_ERROR : READ;
      default:
        nxt = NO_OP;
    endcase
  end

  assign wr_ok   = (nxt == WRITE) || (nxt == WR_RD);
  assign rd_ok   = (nxt == READ) || (nxt == WR_RD);
  assign cnt_nxt = count + CW'(wr_ok) - CW'(rd_ok);

  always_ff @(posedge clk) begin
    if (reset_n && wr_ok) mem[tail] <= bus.din;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= INIT;
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      dout    <= '0;
      rd_miss <= 1'b0;
      full    <= 1'b0;
      afull   <= 1'b0;
      empty   <= 1'b1;
      aempty  <= 1'b1;
    end else begin
      state   <= nxt;
      rd_miss <= miss;
      count   <= cnt_nxt;
      if (wr_ok) tail <= tail + 1'b1;
      if (rd_ok) begin
        head <= head + 1'b1;
        dout <= mem[head];
      end
      full   <= cnt_nxt == CW'(DEPTH);
      empty  <= cnt_nxt == '0;
      afull  <= cnt_nxt >= CW'(AF_THRESH);
      aempty <= cnt_nxt <= CW'(AE_THRESH);
    end
  end

  assign bus.dout         = dout;
  assign bus.data_count   = count;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = afull;
  assign bus.almost_empty = aempty;
  assign bus.wr_ack = (state == WRITE) || (state == WR_RD);
  assign bus.rd_ack = (state == READ) || (state == WR_RD);
  assign bus.wr_err = state == WR_ERROR;
  assign bus.rd_err = (state == RD_ERROR) || rd_miss;
endmodule

// File: tb/tb_fifo_param.sv
// Bench for fifo_param: directed vector table, corner sequences
// and random traffic against a queue-based reference.
module tb_fifo_param;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  fifo_param_if #(.DATA_WIDTH(32), .ADDR_WIDTH(3)) bus ();

  fifo_param #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(3),
    .AF_THRESH (7),
    .AE_THRESH (1)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int errors = 0;
  int checks = 0;

  logic [31:0] q[$];
  logic [31:0] m_dout;
  bit m_wa, m_we, m_ra, m_re;

  typedef struct {
    bit          rst;
    bit          w;
    bit          r;
    logic [31:0] din;
    logic [31:0] dout;
    int          cnt;
    bit          wa;
    bit          we;
    bit          ra;
    bit          re;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // Reference: FIFO as a queue, outcomes from occupancy rules.
  task automatic model(bit rst, bit w, bit r,
                       logic [31:0] d);
    m_wa = 0; m_we = 0; m_ra = 0; m_re = 0;
    if (rst) begin
      q.delete();
      m_dout = '0;
    end else if (w && r) begin
      if (q.size() == 0) begin
        q.push_back(d);
        m_wa = 1; m_re = 1;
      end else begin
        m_dout = q.pop_front();
        q.push_back(d);
        m_wa = 1; m_ra = 1;
      end
    end else if (w) begin
      if (q.size() < 8) begin
        q.push_back(d);
        m_wa = 1;
      end else m_we = 1;
    end else if (r) begin
      if (q.size() > 0) begin
        m_dout = q.pop_front();
        m_ra = 1;
      end else m_re = 1;
    end
  endtask

  task automatic cycle(bit rst, bit w, bit r,
                       logic [31:0] d);
    @(negedge clk);
    reset_n   = !rst;
    bus.wr_en = w;
    bus.rd_en = r;
    bus.din   = d;
    @(posedge clk);
    #1;
    model(rst, w, r, d);
  endtask

  task automatic check_exp(string t, logic [31:0] dv,
                           int c, bit wa, bit we,
                           bit ra, bit re);
    chk({t, ".dout"}, bus.dout, dv);
    chk({t, ".count"}, 32'(bus.data_count), 32'(c));
    chk({t, ".full"}, 32'(bus.full), 32'(c == 8));
    chk({t, ".empty"}, 32'(bus.empty), 32'(c == 0));
    chk({t, ".af"}, 32'(bus.almost_full), 32'(c >= 7));
    chk({t, ".ae"}, 32'(bus.almost_empty), 32'(c <= 1));
    chk({t, ".wr_ack"}, 32'(bus.wr_ack), 32'(wa));
    chk({t, ".wr_err"}, 32'(bus.wr_err), 32'(we));
    chk({t, ".rd_ack"}, 32'(bus.rd_ack), 32'(ra));
    chk({t, ".rd_err"}, 32'(bus.rd_err), 32'(re));
  endtask

  task automatic check_model(string t);
    check_exp(t, m_dout, q.size(), m_wa, m_we, m_ra, m_re);
  endtask

  function automatic void add(bit rst, bit w, bit r,
                              logic [31:0] din,
                              logic [31:0] dv, int c,
                              bit wa, bit we,
                              bit ra, bit re);
    vec_t v;
    v.rst = rst; v.w = w; v.r = r; v.din = din;
    v.dout = dv; v.cnt = c;
    v.wa = wa; v.we = we; v.ra = ra; v.re = re;
    tbl.push_back(v);
  endfunction

  initial begin
    bus.wr_en = 0;
    bus.rd_en = 0;
    bus.din   = '0;
    m_dout    = '0;

    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++)
      add(0, 1, 0, 32'((i + 1) * 'h11), 0, i + 1,
          1, 0, 0, 0);
    add(0, 1, 0, 32'h99, 0, 8, 0, 1, 0, 0);
    for (int i = 0; i < 8; i++)
      add(0, 0, 1, 0, 32'((i + 1) * 'h11), 7 - i,
          0, 0, 1, 0);
    add(0, 0, 1, 0, 32'h88, 0, 0, 0, 0, 1);

    foreach (tbl[i]) begin
      cycle(tbl[i].rst, tbl[i].w, tbl[i].r, tbl[i].din);
      check_exp($sformatf("vec%0d", i), tbl[i].dout,
                tbl[i].cnt, tbl[i].wa, tbl[i].we,
                tbl[i].ra, tbl[i].re);
    end

    // wrap-around through pointer 0
    for (int i = 0; i < 5; i++) begin
      cycle(0, 1, 0, $urandom);
      check_model("wrap_w5");
    end
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, 1, 0);
      check_model("wrap_r5");
    end
    for (int i = 0; i < 8; i++) begin
      cycle(0, 1, 0, 32'hA0 + 32'(i));
      check_model("wrap_w8");
    end
    for (int i = 0; i < 8; i++) begin
      cycle(0, 0, 1, 0);
      check_model("wrap_r8");
      chk("wrap_data", bus.dout, 32'hA0 + 32'(i));
    end

    // simultaneous access at count 3, full and empty
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, $urandom);
    cycle(0, 1, 1, 32'hBEEF);
    check_model("both_mid");
    for (int i = 0; i < 5; i++) cycle(0, 1, 0, $urandom);
    check_model("fill");
    cycle(0, 1, 1, 32'h1234);
    check_model("both_full");
    for (int i = 0; i < 8; i++) begin
      cycle(0, 0, 1, 0);
      check_model("drain");
    end
    cycle(0, 1, 1, 32'h5A5A);
    check_model("both_empty");
    cycle(0, 0, 1, 0);
    check_model("both_empty_rd");

    // reset mid-stream with a write pending
    for (int i = 0; i < 5; i++) cycle(0, 1, 0, $urandom);
    check_model("pre_rst");
    cycle(1, 1, 0, 32'hDEAD);
    check_model("mid_rst");
    cycle(0, 0, 1, 0);
    check_model("post_rst_rd");

    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 49) == 0,
            $urandom_range(0, 1) == 1,
            $urandom_range(0, 1) == 1, $urandom);
      check_model($sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end
endmodule
